data_mem_arb: RTL and testbench

DATA_MEM_ARB -- requirements
Module: DATA_MEM_ARB

---
 rtl/data_mem_arb_pkg.sv | 28 ++
 rtl/data_mem_arb_rr_arb2.sv | 35 +++
 rtl/data_mem_arb.sv | 188 ++++++++++++++++++
 tb/tb_data_mem_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_arb_pkg
//
// Purpose:
//   Shared constants for the data-memory arbiter slice: the FSM state
//   encoding, the default memory-wait timeout, the default data width and
//   the width of the busy-cycle counter.
//
// Contents:
//   arb_state_t      IDLE=2'd0, BUSY=2'd1, RESP=2'd2
//   DEFAULT_TIMEOUT  default number of BUSY cycles before giving up on memory
//   DEFAULT_XLEN     default address/data width
//   CNT_W            counter width; 8 bits covers the full TIMEOUT range 2..255
// ---------------------------------------------------------------------------
package data_mem_arb_pkg;

  // One transaction in flight: wait for a request, talk to memory, answer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 16;
  localparam int DEFAULT_XLEN    = 32;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/data_mem_arb_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//
// Purpose:
//   Purely combinational two-way round-robin selector. A lone request always
//   wins; when both requesters ask at once, the one that was NOT granted last
//   time wins.
//
// Ports:
//   req0, req1   request lines (0 = core LSU, 1 = debug/DMA)
//   last_grant   index of the requester granted most recently
//   grant_valid  at least one request is present
//   grant_idx    index of the winner (only meaningful with grant_valid)
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  // On a tie the winner is the complement of the last grant, which gives
  // strict alternation under continuous contention.
  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = 1'b0;
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arb.sv
// ---------------------------------------------------------------------------
// data_mem_arb
//
// Purpose:
//   Arbitrates two requesters (core LSU on port 0, debug/DMA on port 1) onto
//   a single data-memory port. One transaction is in flight at a time:
//     IDLE - pick a winner round-robin and latch its write/addr/data
//     BUSY - present the latched request to memory until mem_ready_in or
//            until TIMEOUT cycles have passed
//     RESP - one-cycle ready pulse (plus err/data) back to the winner
//   The memory-side outputs come only from registers, so there is no
//   combinational path from the requester inputs to the memory port.
//
// Parameters:
//   XLEN     address/data width
//   TIMEOUT  max BUSY cycles waiting on mem_ready_in (2..255)
//
// Ports:
//   clk_in, rst_in                      clock (rising edge), async active-high reset
//   req{0,1}_valid_in/_write_in         request present / 1 = store
//   req{0,1}_addr_in/_data_in           address / store data
//   req{0,1}_ready_out                  one-cycle completion pulse
//   req{0,1}_err_out                    timeout flag, valid with ready
//   req{0,1}_data_out                   load data, valid with ready
//   mem_valid_out/_write_out            request to data memory
//   mem_addr_out/_data_out              latched address / store data
//   mem_ready_in, mem_data_in           completion and load data from memory
// ---------------------------------------------------------------------------
module data_mem_arb
  import data_mem_arb_pkg::*;
#(
  parameter int XLEN    = DEFAULT_XLEN,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk_in,
  input  logic            rst_in,

  input  logic            req0_valid_in,
  input  logic            req0_write_in,
  input  logic [XLEN-1:0] req0_addr_in,
  input  logic [XLEN-1:0] req0_data_in,
  output logic            req0_ready_out,
  output logic            req0_err_out,
  output logic [XLEN-1:0] req0_data_out,

  input  logic            req1_valid_in,
  input  logic            req1_write_in,
  input  logic [XLEN-1:0] req1_addr_in,
  input  logic [XLEN-1:0] req1_data_in,
  output logic            req1_ready_out,
  output logic            req1_err_out,
  output logic [XLEN-1:0] req1_data_out,

  output logic            mem_valid_out,
  output logic            mem_write_out,
  output logic [XLEN-1:0] mem_addr_out,
  output logic [XLEN-1:0] mem_data_out,
  input  logic            mem_ready_in,
  input  logic [XLEN-1:0] mem_data_in
);

  // Counter value on the last BUSY cycle we are willing to wait.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state_q;
  arb_state_t       state_d;

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_hit;

  // last_grant_q is the round-robin pointer (resets to 1 so port 0 wins the
  // first tie); grant_idx_q selects which port gets the response pulse.
  logic             last_grant_q;
  logic             grant_idx_q;

  logic             lat_write_q;
  logic [XLEN-1:0]  lat_addr_q;
  logic [XLEN-1:0]  lat_data_q;

  logic [XLEN-1:0]  resp_data_q;
  logic             resp_err_q;

  logic             arb_valid;
  logic             arb_idx;

  rr_arb2 u_rr_arb2 (
    .req0        (req0_valid_in),
    .req1        (req1_valid_in),
    .last_grant  (last_grant_q),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  assign timeout_hit = (cnt_q == CNT_LAST);

  // State register. Reset abandons any transaction in flight immediately.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. mem_ready_in is checked before the timeout so that a
  // completion on the final allowed cycle still counts as a normal one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready_in || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch, round-robin pointer, busy counter and response register.
  // The counter restarts at zero on every grant so each BUSY phase gets the
  // full TIMEOUT window; load data is captured for stores too.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_idx_q  <= 1'b0;
      lat_write_q  <= 1'b0;
      lat_addr_q   <= '0;
      lat_data_q   <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            cnt_q        <= '0;
            last_grant_q <= arb_idx;
            grant_idx_q  <= arb_idx;
            lat_write_q  <= arb_idx ? req1_write_in : req0_write_in;
            lat_addr_q   <= arb_idx ? req1_addr_in  : req0_addr_in;
            lat_data_q   <= arb_idx ? req1_data_in  : req0_data_in;
          end
        end
        BUSY: begin
          if (mem_ready_in) begin
            resp_data_q <= mem_data_in;
            resp_err_q  <= 1'b0;
          end else if (timeout_hit) begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs. Memory side is driven purely from the latched fields; the
  // response pulse goes only to the granted port while both ports share the
  // same response data bus.
  always_comb begin
    mem_valid_out  = (state_q == BUSY);
    mem_write_out  = lat_write_q;
    mem_addr_out   = lat_addr_q;
    mem_data_out   = lat_data_q;

    req0_ready_out = (state_q == RESP) && !grant_idx_q;
    req1_ready_out = (state_q == RESP) &&  grant_idx_q;
    req0_err_out   = (state_q == RESP) && !grant_idx_q && resp_err_q;
    req1_err_out   = (state_q == RESP) &&  grant_idx_q && resp_err_q;
    req0_data_out  = resp_data_q;
    req1_data_out  = resp_data_q;
  end

endmodule

// File: tb/tb_data_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arb
//
// Bench for data_mem_arb: a table of directed transactions with constant
// expectations, hand-written reset and idle-noise sequences, then random
// transactions scored against a simple round-robin / timeout model.
// ---------------------------------------------------------------------------
module tb_data_mem_arb;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic            clk_in;
  logic            rst_in;
  logic            req0_valid_in, req0_write_in;
  logic [XLEN-1:0] req0_addr_in, req0_data_in;
  logic            req0_ready_out, req0_err_out;
  logic [XLEN-1:0] req0_data_out;
  logic            req1_valid_in, req1_write_in;
  logic [XLEN-1:0] req1_addr_in, req1_data_in;
  logic            req1_ready_out, req1_err_out;
  logic [XLEN-1:0] req1_data_out;
  logic            mem_valid_out, mem_write_out;
  logic [XLEN-1:0] mem_addr_out, mem_data_out;
  logic            mem_ready_in;
  logic [XLEN-1:0] mem_data_in;

  data_mem_arb #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .req0_valid_in  (req0_valid_in),
    .req0_write_in  (req0_write_in),
    .req0_addr_in   (req0_addr_in),
    .req0_data_in   (req0_data_in),
    .req0_ready_out (req0_ready_out),
    .req0_err_out   (req0_err_out),
    .req0_data_out  (req0_data_out),
    .req1_valid_in  (req1_valid_in),
    .req1_write_in  (req1_write_in),
    .req1_addr_in   (req1_addr_in),
    .req1_data_in   (req1_data_in),
    .req1_ready_out (req1_ready_out),
    .req1_err_out   (req1_err_out),
    .req1_data_out  (req1_data_out),
    .mem_valid_out  (mem_valid_out),
    .mem_write_out  (mem_write_out),
    .mem_addr_out   (mem_addr_out),
    .mem_data_out   (mem_data_out),
    .mem_ready_in   (mem_ready_in),
    .mem_data_in    (mem_data_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // One transaction: both requester fields, the BUSY cycle index (0-based)
  // on which memory answers (>= TIMEOUT means never), the memory load data,
  // and the expected winner / err / data / number of BUSY cycles.
  typedef struct {
    logic            v0;
    logic            w0;
    logic [XLEN-1:0] a0;
    logic [XLEN-1:0] d0;
    logic            v1;
    logic            w1;
    logic [XLEN-1:0] a1;
    logic [XLEN-1:0] d1;
    int              lat;
    logic [XLEN-1:0] rdata;
    int              exp_port;
    logic            exp_err;
    logic [XLEN-1:0] exp_data;
    int              exp_busy;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic noisy    = 1'b0;

  vec_t vecs [8];
  vec_t rv;
  int   model_last;
  logic pend0, pend1;

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                             input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one request set at a negedge, plays the memory side, and checks
  // the memory request, the BUSY length and the response pulse. Only the
  // winner drops valid after its pulse; a losing requester keeps waiting.
  task automatic applyStimulus(input vec_t v, input string tag);
    int              busy;
    int              resp_iter;
    logic            done;
    logic            r0, r1, e0, e1;
    logic [XLEN-1:0] q0, q1;
    logic            exp_w;
    logic [XLEN-1:0] exp_a, exp_d;

    busy = 0; resp_iter = 0; done = 1'b0;
    r0 = 1'b0; r1 = 1'b0; e0 = 1'b0; e1 = 1'b0; q0 = '0; q1 = '0;
    exp_w = (v.exp_port == 0) ? v.w0 : v.w1;
    exp_a = (v.exp_port == 0) ? v.a0 : v.a1;
    exp_d = (v.exp_port == 0) ? v.d0 : v.d1;

    @(negedge clk_in);
    req0_valid_in = v.v0; req0_write_in = v.w0; req0_addr_in = v.a0; req0_data_in = v.d0;
    req1_valid_in = v.v1; req1_write_in = v.w1; req1_addr_in = v.a1; req1_data_in = v.d1;
    mem_ready_in  = 1'b0;
    @(posedge clk_in);

    for (int c = 1; c <= TIMEOUT + 4 && !done; c++) begin
      @(negedge clk_in);
      if (mem_valid_out) begin
        busy++;
        if (busy == 1) begin
          checkOutput({tag, " mem_write"}, {31'd0, mem_write_out}, {31'd0, exp_w});
          checkOutput({tag, " mem_addr"}, mem_addr_out, exp_a);
          checkOutput({tag, " mem_data"}, mem_data_out, exp_d);
        end
        if (busy - 1 == v.lat) begin
          mem_ready_in = 1'b1;
          mem_data_in  = v.rdata;
        end else begin
          mem_ready_in = 1'b0;
          mem_data_in  = $urandom;
        end
      end else begin
        r0 = req0_ready_out; r1 = req1_ready_out;
        e0 = req0_err_out;   e1 = req1_err_out;
        q0 = req0_data_out;  q1 = req1_data_out;
        resp_iter = c;
        done = 1'b1;
        mem_ready_in = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_data_in  = $urandom;
        if (v.exp_port == 0) req0_valid_in = 1'b0;
        else                 req1_valid_in = 1'b0;
      end
    end

    checkOutput({tag, " response seen"}, {31'd0, done}, 32'd1);
    checkOutput({tag, " busy cycles"}, 32'(busy), 32'(v.exp_busy));
    checkOutput({tag, " response cycle"}, 32'(resp_iter), 32'(v.exp_busy + 1));
    checkOutput({tag, " ready0"}, {31'd0, r0}, {31'd0, v.exp_port == 0});
    checkOutput({tag, " ready1"}, {31'd0, r1}, {31'd0, v.exp_port == 1});
    checkOutput({tag, " err0"}, {31'd0, e0}, {31'd0, (v.exp_port == 0) && v.exp_err});
    checkOutput({tag, " err1"}, {31'd0, e1}, {31'd0, (v.exp_port == 1) && v.exp_err});
    checkOutput({tag, " data0"}, q0, v.exp_data);
    checkOutput({tag, " data1"}, q1, v.exp_data);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " mem_valid"}, {31'd0, mem_valid_out}, 32'd0);
    checkOutput({tag, " ready0"}, {31'd0, req0_ready_out}, 32'd0);
    checkOutput({tag, " ready1"}, {31'd0, req1_ready_out}, 32'd0);
  endtask

  initial begin
    rst_in = 1'b1;
    req0_valid_in = 1'b0; req0_write_in = 1'b0; req0_addr_in = '0; req0_data_in = '0;
    req1_valid_in = 1'b0; req1_write_in = 1'b0; req1_addr_in = '0; req1_data_in = '0;
    mem_ready_in = 1'b0; mem_data_in = '0;

    //              v0   w0    a0        d0            v1   w1    a1        d1            lat rdata          port err   data           busy
    vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'h44, 32'h0,        0,  32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 1};
    vecs[1] = '{1'b1, 1'b0, 32'h14, 32'h0,        1'b1, 1'b0, 32'h44, 32'h0,        2,  32'h11112222, 1, 1'b0, 32'h11112222, 3};
    vecs[2] = '{1'b1, 1'b0, 32'h14, 32'h0,        1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 1,  32'h33334444, 0, 1'b0, 32'h33334444, 2};
    vecs[3] = '{1'b1, 1'b0, 32'h18, 32'h0,        1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 4,  32'h0BADF00D, 1, 1'b0, 32'h0BADF00D, 5};
    vecs[4] = '{1'b1, 1'b0, 32'h18, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        15, 32'h55AA55AA, 0, 1'b0, 32'h55AA55AA, 16};
    vecs[5] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h20, 32'h12345678, 99, 32'h77777777, 1, 1'b1, 32'h0,        16};
    vecs[6] = '{1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,  32'h0,        14, 32'h01020304, 0, 1'b0, 32'h01020304, 15};
    vecs[7] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h3C, 32'h0,        16, 32'h99999999, 1, 1'b1, 32'h0,        16};

    // Reset state.
    #1;
    checkQuiet("reset");
    checkOutput("reset err0", {31'd0, req0_err_out}, 32'd0);
    checkOutput("reset err1", {31'd0, req1_err_out}, 32'd0);
    checkOutput("reset data0", req0_data_out, 32'd0);
    checkOutput("reset mem_addr", mem_addr_out, 32'd0);
    checkOutput("reset mem_write", {31'd0, mem_write_out}, 32'd0);
    @(posedge clk_in);
    @(posedge clk_in);
    #2 rst_in = 1'b0;

    $display("[TB] directed table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a BUSY phase after req0 took the pointer.
    $display("[TB] reset mid-BUSY");
    @(negedge clk_in);
    req0_valid_in = 1'b1; req0_write_in = 1'b0; req0_addr_in = 32'h40; req0_data_in = '0;
    @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("pre-reset mem_valid", {31'd0, mem_valid_out}, 32'd1);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    checkQuiet("mid-busy reset");
    checkOutput("mid-busy reset mem_addr", mem_addr_out, 32'd0);
    req0_valid_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_in);
      checkQuiet($sformatf("in reset %0d", k));
    end
    @(posedge clk_in);
    #2 rst_in = 1'b0;
    rv = '{1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 32'h54, 32'h0, 0, 32'hA5A5A5A5, 0, 1'b0, 32'hA5A5A5A5, 1};
    applyStimulus(rv, "post-reset tie");
    rv = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h54, 32'h0, 1, 32'h5A5A5A5A, 1, 1'b0, 32'h5A5A5A5A, 2};
    applyStimulus(rv, "post-reset req1");

    // mem_ready_in wiggling while nothing is in flight must do nothing.
    $display("[TB] idle noise");
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      checkQuiet($sformatf("idle noise %0d", k));
      mem_ready_in = 1'(k % 2);
      mem_data_in  = $urandom;
    end
    noisy = 1'b1;
    rv = '{1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2, 32'h600D600D, 0, 1'b0, 32'h600D600D, 3};
    applyStimulus(rv, "noisy txn");
    @(negedge clk_in);
    checkQuiet("after noisy resp");
    mem_ready_in = 1'b0;
    noisy = 1'b0;

    // Random transactions against the model. Pointer: last grant was req0.
    $display("[TB] random");
    model_last = 0;
    pend0 = 1'b0; pend1 = 1'b0;
    rv = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0, 0, 1'b0, 32'h0, 1};
    for (int n = 0; n < 40; n++) begin
      if (!pend0) begin
        rv.v0 = 1'($urandom_range(0, 1));
        rv.w0 = 1'($urandom_range(0, 1));
        rv.a0 = $urandom;
        rv.d0 = $urandom;
      end
      if (!pend1) begin
        rv.v1 = 1'($urandom_range(0, 1));
        rv.w1 = 1'($urandom_range(0, 1));
        rv.a1 = $urandom;
        rv.d1 = $urandom;
      end
      if (!rv.v0 && !rv.v1) begin
        if ($urandom_range(0, 1) == 0) rv.v0 = 1'b1;
        else                           rv.v1 = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) rv.lat = TIMEOUT + int'($urandom_range(0, 3));
      else                           rv.lat = int'($urandom_range(0, TIMEOUT - 1));
      rv.rdata = $urandom;

      if (rv.v0 && rv.v1) rv.exp_port = (model_last == 1) ? 0 : 1;
      else                rv.exp_port = rv.v0 ? 0 : 1;
      model_last = rv.exp_port;
      if (rv.lat < TIMEOUT) begin
        rv.exp_err  = 1'b0;
        rv.exp_data = rv.rdata;
        rv.exp_busy = rv.lat + 1;
      end else begin
        rv.exp_err  = 1'b1;
        rv.exp_data = '0;
        rv.exp_busy = TIMEOUT;
      end

      applyStimulus(rv, $sformatf("rand%0d", n));
      pend0 = rv.v0 && (rv.exp_port != 0);
      pend1 = rv.v1 && (rv.exp_port != 1);
    end

    @(negedge clk_in);
    req0_valid_in = 1'b0;
    req1_valid_in = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
